// File: rtl/complex_to_mag_mc_pkg.sv
// Shared definitions for the multi-channel magnitude estimator:
// estimator mode encodings and the fixed pipeline depth.
package complex_to_mag_mc_pkg;

  localparam logic [1:0] MAG_MODE_AMBM_Q  = 2'd0;
  localparam logic [1:0] MAG_MODE_AMBM_3E = 2'd1;
  localparam logic [1:0] MAG_MODE_AMBM_H  = 2'd2;
  localparam logic [1:0] MAG_MODE_BEST2   = 2'd3;

  localparam int unsigned MAG_LATENCY = 4;

endpackage

// File: rtl/mag_peak_bank.sv
// Per-channel peak-magnitude registers with clear/update arbitration
// and a one-cycle registered read port.
module mag_peak_bank #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  upd_vld_i,
  input  logic [CH_W-1:0]       upd_ch_i,
  input  logic [DATA_WIDTH-1:0] upd_val_i,
  input  logic                  clear_i,
  input  logic [CH_W-1:0]       sel_i,
  output logic [DATA_WIDTH-1:0] peak_o
);

  logic [DATA_WIDTH-1:0] peak_q [NUM_CH];
  logic [DATA_WIDTH-1:0] peak_d [NUM_CH];
  logic [DATA_WIDTH-1:0] peak_out_q;
  logic [DATA_WIDTH-1:0] peak_out_d;

  // Clear wins over the old peak, but the channel being updated this cycle keeps the new mag.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      peak_d[k] = peak_q[k];
      if (enable_i) begin
        if (clear_i) begin
          peak_d[k] = (upd_vld_i && (upd_ch_i == CH_W'(k))) ? upd_val_i : '0;
        end else if (upd_vld_i && (upd_ch_i == CH_W'(k)) && (upd_val_i > peak_q[k])) begin
          peak_d[k] = upd_val_i;
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    peak_out_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel_i == CH_W'(k)) begin
        peak_out_d = peak_q[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        peak_q[k] <= '0;
      end
      peak_out_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        peak_q[k] <= peak_d[k];
      end
      peak_out_q <= peak_out_d;
    end
  end

  assign peak_o = peak_out_q;

endmodule

// File: rtl/complex_to_mag_mc.sv
// Multi-channel alpha-max-plus-beta-min magnitude estimator: 4-stage
// pipeline with per-sample mode select and a per-channel peak bank.
module complex_to_mag_mc
  import complex_to_mag_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i,
  input  logic [DATA_WIDTH-1:0] q,
  input  logic                  input_strobe,
  input  logic [CH_W-1:0]       ch_in,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] mag,
  output logic                  mag_stb,
  output logic [CH_W-1:0]       mag_ch,
  input  logic                  peak_clear,
  input  logic [CH_W-1:0]       peak_sel,
  output logic [DATA_WIDTH-1:0] peak_out
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  // Stage 1: absolute values
  logic                  s1_vld_q;
  logic [CH_W-1:0]       s1_ch_q;
  logic [1:0]            s1_mode_q;
  logic [DATA_WIDTH-1:0] s1_abs_i_q, s1_abs_q_q;
  logic [DATA_WIDTH-1:0] abs_i_d, abs_q_d;

  // Stage 2: max/min
  logic                  s2_vld_q;
  logic [CH_W-1:0]       s2_ch_q;
  logic [1:0]            s2_mode_q;
  logic [DATA_WIDTH-1:0] s2_max_q, s2_min_q;
  logic [DATA_WIDTH-1:0] max_d, min_d;

  // Stage 3: candidate sums with one guard bit
  logic                  s3_vld_q;
  logic [CH_W-1:0]       s3_ch_q;
  logic [1:0]            s3_mode_q;
  logic [SUM_W-1:0]      s3_a_q, s3_b_q;
  logic [SUM_W-1:0]      mx_e, mn_e, a_d, b_d;

  // Stage 4: output
  logic                  mag_stb_q;
  logic [CH_W-1:0]       mag_ch_q;
  logic [DATA_WIDTH-1:0] mag_q;
  logic [DATA_WIDTH-1:0] mag_d;
  logic                  use_b;

  // Most negative input maps to 2^(W-1) as an unsigned pattern, no wrap.
  always_comb begin
    abs_i_d = i[DATA_WIDTH-1] ? (~i + DATA_WIDTH'(1)) : i;
    abs_q_d = q[DATA_WIDTH-1] ? (~q + DATA_WIDTH'(1)) : q;
  end

  always_comb begin
    max_d = (s1_abs_i_q >= s1_abs_q_q) ? s1_abs_i_q : s1_abs_q_q;
    min_d = (s1_abs_i_q >= s1_abs_q_q) ? s1_abs_q_q : s1_abs_i_q;
  end

  always_comb begin
    mx_e = SUM_W'(s2_max_q);
    mn_e = SUM_W'(s2_min_q);
    a_d  = mx_e + (mn_e >> 2);
    b_d  = '0;
    case (s2_mode_q)
      MAG_MODE_AMBM_3E: a_d = mx_e + (mn_e >> 2) + (mn_e >> 3);
      MAG_MODE_AMBM_H:  a_d = mx_e + (mn_e >> 1);
      MAG_MODE_BEST2: begin
        a_d = mx_e + (mn_e >> 3);
        b_d = mx_e - (mx_e >> 3) + (mn_e >> 1);
      end
      default: a_d = mx_e + (mn_e >> 2);
    endcase
  end

  // Guard bit is always zero by the width argument; drop it here.
  always_comb begin
    use_b = (s3_mode_q == MAG_MODE_BEST2) && (s3_b_q > s3_a_q);
    mag_d = use_b ? DATA_WIDTH'(s3_b_q) : DATA_WIDTH'(s3_a_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_mode_q  <= '0;
      s1_abs_i_q <= '0;
      s1_abs_q_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_ch_q    <= '0;
      s2_mode_q  <= '0;
      s2_max_q   <= '0;
      s2_min_q   <= '0;
      s3_vld_q   <= 1'b0;
      s3_ch_q    <= '0;
      s3_mode_q  <= '0;
      s3_a_q     <= '0;
      s3_b_q     <= '0;
      mag_stb_q  <= 1'b0;
      mag_ch_q   <= '0;
      mag_q      <= '0;
    end else if (enable) begin
      s1_vld_q   <= input_strobe;
      s1_ch_q    <= ch_in;
      s1_mode_q  <= mode;
      s1_abs_i_q <= abs_i_d;
      s1_abs_q_q <= abs_q_d;
      s2_vld_q   <= s1_vld_q;
      s2_ch_q    <= s1_ch_q;
      s2_mode_q  <= s1_mode_q;
      s2_max_q   <= max_d;
      s2_min_q   <= min_d;
      s3_vld_q   <= s2_vld_q;
      s3_ch_q    <= s2_ch_q;
      s3_mode_q  <= s2_mode_q;
      s3_a_q     <= a_d;
      s3_b_q     <= b_d;
      mag_stb_q  <= s3_vld_q;
      mag_ch_q   <= s3_ch_q;
      if (s3_vld_q) begin
        mag_q <= mag_d;
      end
    end
  end

  assign mag     = mag_q;
  assign mag_stb = mag_stb_q;
  assign mag_ch  = mag_ch_q;

  mag_peak_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W)
  ) u_peak_bank (
    .clock     (clock),
    .reset     (reset),
    .enable_i  (enable),
    .upd_vld_i (mag_stb_q),
    .upd_ch_i  (mag_ch_q),
    .upd_val_i (mag_q),
    .clear_i   (peak_clear),
    .sel_i     (peak_sel),
    .peak_o    (peak_out)
  );

endmodule

// File: tb/tb_complex_to_mag_mc.sv
// Scoreboard bench for complex_to_mag_mc: directed cases from the plan
// plus randomized traffic against an arithmetic reference model.
module tb_complex_to_mag_mc;
  import complex_to_mag_mc_pkg::*;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CW  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] i, q;
  logic          input_strobe;
  logic [CW-1:0] ch_in;
  logic [1:0]    mode;
  logic [DW-1:0] mag;
  logic          mag_stb;
  logic [CW-1:0] mag_ch;
  logic          peak_clear;
  logic [CW-1:0] peak_sel;
  logic [DW-1:0] peak_out;

  always #5 clock = ~clock;

  complex_to_mag_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .i            (i),
    .q            (q),
    .input_strobe (input_strobe),
    .ch_in        (ch_in),
    .mode         (mode),
    .mag          (mag),
    .mag_stb      (mag_stb),
    .mag_ch       (mag_ch),
    .peak_clear   (peak_clear),
    .peak_sel     (peak_sel),
    .peak_out     (peak_out)
  );

  typedef struct {
    int mag;
    int ch;
    int stamp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_edges = 0;
  bit   en_seen = 1'b0;
  bit   rst_seen = 1'b1;
  int   peak_m[NCH];
  int   exp_peak_out = 0;
  bit   cur_vld = 1'b0;
  int   cur_mag = 0;
  int   cur_ch = 0;
  bit   ev;
  exp_t e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference estimator from the plain arithmetic definitions.
  function automatic int est(input int ii, input int qq, input int m);
    int ai, aq, mx, mn, a, b;
    ai = (ii < 0) ? -ii : ii;
    aq = (qq < 0) ? -qq : qq;
    mx = (ai > aq) ? ai : aq;
    mn = (ai > aq) ? aq : ai;
    case (m)
      0: return mx + mn / 4;
      1: return mx + mn / 4 + mn / 8;
      2: return mx + mn / 2;
      default: begin
        a = mx + mn / 8;
        b = mx - mx / 8 + mn / 2;
        return (a > b) ? a : b;
      end
    endcase
  endfunction

  // Model of the peak bank and of enabled-edge timing.
  always @(posedge clock) begin
    en_seen  = enable && !reset;
    rst_seen = reset;
    if (reset) begin
      exp_peak_out = 0;
      for (int k = 0; k < NCH; k++) peak_m[k] = 0;
      sb.delete();
      cur_vld = 1'b0;
    end else begin
      exp_peak_out = (peak_sel < NCH) ? peak_m[peak_sel] : 0;
      if (enable) begin
        en_edges++;
        if (peak_clear) begin
          for (int k = 0; k < NCH; k++)
            peak_m[k] = (cur_vld && cur_ch == k) ? cur_mag : 0;
        end else if (cur_vld && cur_ch < NCH && cur_mag > peak_m[cur_ch]) begin
          peak_m[cur_ch] = cur_mag;
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents after each edge.
  always @(negedge clock) begin
    if (rst_seen) begin
      check("rst_mag_stb", int'(mag_stb), 0);
      check("rst_mag", int'(mag), 0);
      check("rst_mag_ch", int'(mag_ch), 0);
    end else if (en_seen) begin
      ev = (sb.size() > 0) && (sb[0].stamp == en_edges);
      check("mag_stb", int'(mag_stb), int'(ev));
      cur_vld = ev;
      if (ev) begin
        e = sb.pop_front();
        check("mag", int'(mag), e.mag);
        check("mag_ch", int'(mag_ch), e.ch);
        cur_mag = e.mag;
        cur_ch  = e.ch;
      end
    end
    check("peak_out", int'(peak_out), exp_peak_out);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // expv < 0 selects the reference model.
  task automatic drive(input int ii, input int qq, input int m, input int c, input int expv);
    i            = DW'(ii);
    q            = DW'(qq);
    mode         = 2'(m);
    ch_in        = CW'(c);
    input_strobe = 1'b1;
    if (enable && !reset)
      sb.push_back('{(expv < 0) ? est(ii, qq, m) : expv, c, en_edges + int'(MAG_LATENCY)});
    step();
    input_strobe = 1'b0;
  endtask

  function automatic int rand_sample();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; i = '0; q = '0; input_strobe = 1'b0;
    ch_in = '0; mode = '0; peak_clear = 1'b0; peak_sel = '0;
    repeat (3) step();
    reset = 1'b0;

    // Directed estimator cases, including per-sample mode switch.
    drive(3, 4, 0, 1, 4);
    drive(-32768, 0, 0, 1, 32768);
    drive(-32768, -32768, 2, 0, 49152);
    drive(100, -100, 3, 3, 138);
    drive(100, -100, 1, 3, 137);
    repeat (6) step();

    // Back-to-back across channels with a 2-cycle enable gap.
    drive(rand_sample(), rand_sample(), 0, 0, -1);
    drive(rand_sample(), rand_sample(), 1, 1, -1);
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    drive(rand_sample(), rand_sample(), 2, 2, -1);
    drive(rand_sample(), rand_sample(), 3, 3, -1);
    repeat (8) step();

    // Peak tracking on channel 2.
    peak_clear = 1'b1; step(); peak_clear = 1'b0;
    drive(500, 0, 0, 2, 500);
    drive(900, 0, 0, 2, 900);
    drive(300, 0, 0, 2, 300);
    repeat (6) step();
    peak_sel = 3'd2; step();
    check("peak_ch2_max", int'(peak_out), 900);

    // Clear coinciding with a channel 2 update.
    drive(200, 0, 0, 0, 200);
    drive(400, 0, 0, 3, 400);
    drive(70, 0, 0, 2, 70);
    repeat (3) step();
    peak_clear = 1'b1; step(); peak_clear = 1'b0;
    peak_sel = 3'd2; step(); check("peak_clr_ch2", int'(peak_out), 70);
    peak_sel = 3'd0; step(); check("peak_clr_ch0", int'(peak_out), 0);
    peak_sel = 3'd3; step(); check("peak_clr_ch3", int'(peak_out), 0);

    // Out-of-range channel produces output but no peak write.
    drive(1000, 0, 0, 5, 1000);
    repeat (6) step();
    peak_sel = 3'd5; step(); check("peak_sel_oob", int'(peak_out), 0);
    peak_sel = 3'd2; step(); check("peak_ch2_kept", int'(peak_out), 70);

    // Reset with samples in flight.
    drive(rand_sample(), rand_sample(), 0, 1, -1);
    drive(rand_sample(), rand_sample(), 1, 2, -1);
    drive(rand_sample(), rand_sample(), 3, 3, -1);
    reset = 1'b1; step(); reset = 1'b0;
    repeat (4) step();
    check("post_rst_peak2", int'(peak_out), 0);
    drive(3, 4, 3, 1, -1);
    repeat (6) step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      enable     = ($urandom_range(0, 9) != 0);
      peak_clear = ($urandom_range(0, 31) == 0);
      peak_sel   = CW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        drive(rand_sample(), rand_sample(), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 5)), -1);
      else
        step();
    end
    enable = 1'b1; peak_clear = 1'b0;
    repeat (8) step();
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_to_mag_mc.md
Name: complex_to_mag_mc

Overview:
- Multi-channel, mode-selectable successor to the single-channel alpha-max-plus-beta-min magnitude estimator.
- Accepts time-multiplexed complex samples tagged with a channel index.
- Produces a magnitude estimate per sample, with channel tag and strobe, through a fixed 4-stage pipeline.
- Keeps a per-channel peak-magnitude register for AGC/detection logic in openofdm_rx, readable and clearable at run time.

Parameters:
- DATA_WIDTH, 16, width of signed i/q inputs and of the unsigned mag/peak outputs.
- NUM_CH, 4, number of time-multiplexed channels (>=1).
- CH_W, 2, channel tag width = max(1, clog2(NUM_CH)).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  pipeline advance; low freezes every stage, including strobe, tag and peak updates.
- i  in  DATA_WIDTH  signed in-phase sample.
- q  in  DATA_WIDTH  signed quadrature sample.
- input_strobe  in  1  sample valid.
- ch_in  in  CH_W  channel tag of the sample.
- mode  in  2  estimator select, sampled with input_strobe.
- mag  out  DATA_WIDTH  unsigned magnitude estimate.
- mag_stb  out  1  mag valid.
- mag_ch  out  CH_W  channel tag aligned to mag.
- peak_clear  in  1  clears all peak registers.
- peak_sel  in  CH_W  peak read index.
- peak_out  out  DATA_WIDTH  registered peak of channel peak_sel.

Behaviour:
- Reset values: mag, mag_stb, mag_ch, peak_out, all pipeline registers and all peak registers are 0.
- Latency, enable high every cycle: a sample strobed at cycle t appears on mag/mag_stb/mag_ch at t+4.
- Throughput: one sample per cycle. No backpressure.
- Stage 1: abs_i/abs_q = two's-complement magnitude in DATA_WIDTH unsigned bits. -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1) with no wrap. Strobe, ch_in and mode are registered alongside.
- Stage 2: max/min of abs_i and abs_q. When equal, max = min = that value.
- Stage 3: terms per registered mode, all shifts truncating.
  - mode 0: a = max + (min>>2).
  - mode 1: a = max + (min>>2) + (min>>3).
  - mode 2: a = max + (min>>1).
  - mode 3: a = max + (min>>3), b = max - (max>>3) + (min>>1).
- Stage 4: mag = (mode==3) ? larger of a and b : a.
- Width rule: worst case is 1.5*2^(DATA_WIDTH-1) < 2^DATA_WIDTH, so results fit DATA_WIDTH bits. No saturation logic. Intermediate sums carry one guard bit, truncated at stage 4.
- Data stages update only when enable=1. mag holds its value when mag_stb=0 (no zeroing).
- Mode changes take effect on the next strobed sample only; in-flight samples keep their sampled mode.
- Peak update when enable && mag_stb: peak[mag_ch] <= max(peak[mag_ch], mag).
- peak_clear, when enable=1: all peaks <= 0. If peak_clear coincides with a peak update, the target channel's peak becomes that new mag and the others become 0.
- peak_clear while enable=0 is ignored.
- peak_out <= peak[peak_sel] every cycle regardless of enable. One-cycle read latency; it reflects the peak array value before any same-cycle write.
- ch_in >= NUM_CH: sample still produces mag/mag_stb/mag_ch, but no peak register is written. peak_sel >= NUM_CH reads 0.
- Reset mid-stream: all in-flight samples are discarded. First valid output comes 4 enabled cycles after the first post-reset strobe.

Decomposition:
- Shared package holds:
  - mode encodings MAG_MODE_AMBM_Q, MAG_MODE_AMBM_3E, MAG_MODE_AMBM_H, MAG_MODE_BEST2;
  - pipeline depth constant MAG_LATENCY=4.
- One natural sub-module, mag_peak_bank: the NUM_CH peak registers, clear/update arbitration and registered read port.
- The estimator pipeline stays in the top level.

Test Plan:
- mode 0, ch 1: i=3,q=4 -> mag=4, mag_ch=1 at t+4. Then i=-32768,q=0 -> mag=32768.
- mode 2: i=-32768,q=-32768 -> mag=49152, with no overflow.
- mode 3: i=100,q=-100 -> a=112, b=138 -> mag=138. Mode 1 on the same sample, issued the next cycle -> 137; confirms per-sample mode.
- Back-to-back strobes across ch 0..3 with enable deasserted for 2 cycles mid-stream:
  - outputs keep order and tags;
  - total latency = 4 + 2 cycles;
  - no duplicate or lost mag_stb.
- Peak bank:
  - ch 2 receives mags 500, 900, 300 -> peak_sel=2 gives peak_out=900.
  - peak_clear coinciding with ch 2 mag=70 -> peak[2]=70, other channels 0.
  - ch_in=5 with NUM_CH=4 -> no peak change.
- reset asserted with 3 samples in flight -> mag_stb stays 0, all peaks 0. The next strobed sample emerges exactly 4 cycles later.
